// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch : instruction fetch stage feeding the instruction decoder.
//
// Owns the fetch address, loads the reset vector, reads program ROM one word at
// a time over a req/ack interface, buffers returned words and presents them in
// order to the decoder with a valid/ready handshake. Downstream redirects
// (jumps/branches) reload the fetch address and discard prefetched words; a
// read that is still in flight at the redirect completes and is dropped.
//
// Optional feature macro: PREFETCH_EN
//   defined   : prefetch buffer of DEPTH (1 or 2) words, fetching continues
//               while the decoder stalls.
//   undefined : single holding register, next read only after the held word
//               is consumed. DEPTH has no effect.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   MAB, rom_req               ROM word address / read request (out)
//   rom_ack, MDB_in            ROM read acknowledge / read data (in)
//   MDB_out, word_valid, PC    head word, its valid flag and its address (out)
//   word_ready                 decoder consumes the head word (in)
//   redir_valid/rel/val        redirect request, relative flag, target/offset
//   vec_done                   reset vector has been loaded (out)
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [15:0] RESET_VEC = 16'hFFFE,
   parameter int unsigned DEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] MAB,
   output logic        rom_req,
   input  logic        rom_ack,
   input  logic [15:0] MDB_in,
   output logic [15:0] MDB_out,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [15:0] PC,
   input  logic        redir_valid,
   input  logic        redir_rel,
   input  logic [15:0] redir_val,
   output logic        vec_done
);

   localparam int unsigned AW    = 16;
   localparam int unsigned SLOTS = 2;

`ifdef PREFETCH_EN
   localparam int unsigned FD = (DEPTH >= 2) ? 2 : 1;
`else
   // single holding register whatever DEPTH says
   localparam int unsigned FD = (DEPTH != 0) ? 1 : 1;
`endif

   typedef enum logic [1:0] {
      S_VEC      = 2'd0,
      S_VEC_WAIT = 2'd1,
      S_RUN      = 2'd2
   } state_t;

   // one buffered instruction word and the address it was read from
   typedef struct packed {
      logic [AW-1:0] data;
      logic [AW-1:0] addr;
   } fetch_word_t;

   state_t              state, state_nx;
   logic [AW-1:0]       fetch_addr, fetch_d;
   logic [AW-1:0]       last_pc, last_pc_d;
   logic [AW-1:0]       mab_d;
   logic                req_d, stale, stale_d, vec_done_d;
   fetch_word_t         q   [SLOTS];
   fetch_word_t         q_d [SLOTS];
   logic [SLOTS-1:0]    q_vld, q_vld_d;

   logic                ack_c, pop_c, redir_c, issue_c, push_c, clear_c;
   logic [1:0]          occ_c;
   logic                slot_c;
   logic [AW-1:0]       rel_off_c, target_c;

   // head of the buffer drives the decoder side directly from flops
   assign MDB_out    = q[0].data;
   assign PC         = q[0].addr;
   assign word_valid = q_vld[0];

   // handshake and redirect qualifiers
   always_comb begin
      ack_c     = rom_req & rom_ack;
      pop_c     = q_vld[0] & word_ready;
      redir_c   = redir_valid & (state == S_RUN);
      occ_c     = 2'(q_vld[0]) + 2'(q_vld[1]);
      // word offset in [9:0], sign-extended and scaled to bytes
      rel_off_c = {{5{redir_val[9]}}, redir_val[9:0], 1'b0};
      target_c  = redir_rel ? (last_pc + 16'd2 + rel_off_c)
                            : {redir_val[15:1], 1'b0};
      // an in-flight read counts against buffer space
      issue_c   = (state == S_RUN) & ~rom_req & ~redir_c & (32'(occ_c) < FD);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_VEC;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_VEC:      state_nx = S_VEC_WAIT;
         S_VEC_WAIT: if (ack_c) state_nx = S_RUN;
         S_RUN:      state_nx = S_RUN;
         default:    state_nx = S_VEC;
      endcase
   end

   // request, fetch address, stale tracking and last_pc updates
   always_comb begin
      req_d      = rom_req;
      mab_d      = MAB;
      fetch_d    = fetch_addr;
      stale_d    = stale;
      vec_done_d = vec_done;
      last_pc_d  = last_pc;
      push_c     = 1'b0;
      clear_c    = 1'b0;
      case (state)
         S_VEC: begin
            req_d = 1'b1;
            mab_d = RESET_VEC;
         end
         S_VEC_WAIT: begin
            // vector word sets the fetch address and is never buffered
            if (ack_c) begin
               req_d      = 1'b0;
               fetch_d    = {MDB_in[15:1], 1'b0};
               vec_done_d = 1'b1;
            end
         end
         S_RUN: begin
            if (ack_c) begin
               req_d   = 1'b0;
               stale_d = 1'b0;
               if (!stale && !redir_c) begin
                  push_c  = 1'b1;
                  fetch_d = fetch_addr + 16'd2;
               end
            end
            // redirect wins over a sequential advance in the same cycle
            if (redir_c) begin
               fetch_d = target_c;
               clear_c = 1'b1;
               if (rom_req && !ack_c) stale_d = 1'b1;
            end
            if (issue_c) begin
               req_d = 1'b1;
               mab_d = fetch_addr;
            end
            if (pop_c) last_pc_d = q[0].addr;
         end
         default: ;
      endcase
   end

   // buffer next state: shift on pop, append behind the remaining words
   always_comb begin
      for (int i = 0; i < int'(SLOTS); i++) q_d[i] = q[i];
      q_vld_d = q_vld;
      // a push only lands when space was reserved, so the slot is 0 or 1
      slot_c  = pop_c ? 1'b0 : occ_c[0];
      if (clear_c) begin
         q_vld_d = '0;
      end else begin
         if (pop_c) begin
            q_d[0]     = q[1];
            q_vld_d[0] = q_vld[1];
            q_vld_d[1] = 1'b0;
         end
         if (push_c) begin
            q_d[slot_c].data = MDB_in;
            q_d[slot_c].addr = MAB;
            q_vld_d[slot_c]  = 1'b1;
         end
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_req    <= 1'b0;
         MAB        <= RESET_VEC;
         fetch_addr <= '0;
         stale      <= 1'b0;
         vec_done   <= 1'b0;
         last_pc    <= '0;
         q_vld      <= '0;
         for (int i = 0; i < int'(SLOTS); i++) q[i] <= '0;
      end else begin
         rom_req    <= req_d;
         MAB        <= mab_d;
         fetch_addr <= fetch_d;
         stale      <= stale_d;
         vec_done   <= vec_done_d;
         last_pc    <= last_pc_d;
         q_vld      <= q_vld_d;
         for (int i = 0; i < int'(SLOTS); i++) q[i] <= q_d[i];
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch : bench for instr_fetch. A ROM responder with selectable
// latency answers reads; a reference model tracks the address of the next word
// the decoder should see (sequential, wrapped mod 2^16, reloaded on redirects)
// and checks every consumed word.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef PREFETCH_EN
   localparam int unsigned FD_M = 2;
`else
   localparam int unsigned FD_M = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] MAB;
   logic        rom_req;
   logic        rom_ack = 1'b0;
   logic [15:0] MDB_in = '0;
   logic [15:0] MDB_out;
   logic        word_valid;
   logic        word_ready;
   logic [15:0] PC;
   logic        redir_valid;
   logic        redir_rel;
   logic [15:0] redir_val;
   logic        vec_done;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .MAB(MAB), .rom_req(rom_req),
      .rom_ack(rom_ack), .MDB_in(MDB_in), .MDB_out(MDB_out),
      .word_valid(word_valid), .word_ready(word_ready), .PC(PC),
      .redir_valid(redir_valid), .redir_rel(redir_rel),
      .redir_val(redir_val), .vec_done(vec_done)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_pops = 0;
   int          lat_mode = 0;
   logic [15:0] vec_word = 16'hC000;
   logic [15:0] req_q [$];

   function automatic logic [15:0] rom_rd(input logic [15:0] a);
      if (a == 16'hFFFE) return vec_word;
      return 16'((a * 16'd7) ^ 16'h3C5A);
   endfunction

   task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // ROM responder: acks each request after lat_mode cycles (random 0..3 if <0)
   logic        busy = 1'b0;
   logic        acked_last = 1'b0;
   int          cnt = 0;
   logic [15:0] cur_mab = '0;
   always begin
      @(negedge clk);
      rom_ack = 1'b0;
      if (!rst_n) begin
         busy       = 1'b0;
         acked_last = 1'b0;
      end else begin
         if (acked_last) chk(32'(rom_req), 32'(0), "req_drop_after_ack");
         acked_last = 1'b0;
         if (rom_req) begin
            if (!busy) begin
               busy    = 1'b1;
               cur_mab = MAB;
               req_q.push_back(MAB);
               cnt = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
               chk(32'(MAB[0]), 32'(0), "mab_align");
            end else begin
               chk(32'(MAB), 32'(cur_mab), "mab_stable");
            end
            if (cnt == 0) begin
               rom_ack    = 1'b1;
               MDB_in     = rom_rd(MAB);
               busy       = 1'b0;
               acked_last = 1'b1;
            end else begin
               cnt--;
            end
         end
      end
   end

   // reference model: next expected word address, checked on every consume
   logic [15:0] exp_pc = '0;
   logic [15:0] m_last = '0;
   logic        prev_vd = 1'b0;
   always begin
      logic [15:0] pre_last;
      int          off;
      @(negedge clk);
      #4;
      if (!rst_n) begin
         prev_vd = 1'b0;
         m_last  = '0;
      end else begin
         if (!vec_done) chk(32'(word_valid), 32'(0), "valid_before_vec");
         else if (!prev_vd) exp_pc = {vec_word[15:1], 1'b0};
         prev_vd  = vec_done;
         pre_last = m_last;
         if (word_valid && word_ready) begin
            chk(32'(PC), 32'(exp_pc), "pop_pc");
            chk(32'(MDB_out), 32'(rom_rd(exp_pc)), "pop_data");
            n_pops++;
            m_last = exp_pc;
            exp_pc = exp_pc + 16'd2;
         end
         if (redir_valid && vec_done) begin
            off    = int'($signed(redir_val[9:0])) * 2;
            exp_pc = redir_rel ? 16'(int'(pre_last) + 2 + off)
                               : (redir_val & 16'hFFFE);
         end
      end
   end

   task automatic wait_pc(input logic [15:0] a, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         step();
         if (word_valid && PC == a) got = 1'b1;
      end
      chk(32'(got), 32'(1), tag);
   endtask

   task automatic check_next_req(input logic [15:0] e, input string tag);
      int n   = req_q.size();
      bit got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         step();
         if (req_q.size() > n) got = 1'b1;
      end
      chk(32'(got), 32'(1), {tag, "_seen"});
      if (got) chk(32'(req_q[n]), 32'(e), tag);
   endtask

   task automatic redirect(input logic rel, input logic [15:0] v);
      redir_valid = 1'b1;
      redir_rel   = rel;
      redir_val   = v;
      step();
      redir_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      rst_n       = 1'b1;
      word_ready  = 1'b0;
      redir_valid = 1'b0;
      redir_rel   = 1'b0;
      redir_val   = '0;
      lat_mode    = 0;
      #1 rst_n = 1'b0;
      #1;
      chk(32'(rom_req),    32'(0),        "rst_req");
      chk(32'(MAB),        32'(16'hFFFE), "rst_mab");
      chk(32'(word_valid), 32'(0),        "rst_valid");
      chk(32'(MDB_out),    32'(0),        "rst_mdb_out");
      chk(32'(PC),         32'(0),        "rst_pc");
      chk(32'(vec_done),   32'(0),        "rst_vec_done");
      step();
      step();
      rst_n = 1'b1;

      // vector load, then decoder stalled: buffer fills and requests stop
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (vec_done) got = 1'b1;
      end
      chk(32'(got), 32'(1), "vec_done");
      repeat (30) step();
      chk(32'(req_q.size()), 32'(1 + FD_M), "req_count_stall");
      chk(32'(req_q[0]), 32'(16'hFFFE), "vec_mab");
      chk(32'(req_q[1]), 32'(16'hC000), "first_mab");
      chk(32'(rom_req), 32'(0), "req_idle_stall");
      chk(32'(word_valid), 32'(1), "first_valid");
      chk(32'(PC), 32'(16'hC000), "first_pc");
      chk(32'(MDB_out), 32'(rom_rd(16'hC000)), "first_data");
      word_ready = 1'b1;
      check_next_req(16'(32'hC000 + 2 * FD_M), "mab_after_stall");

      // relative jump back from the word at C010
      lat_mode = -1;
      wait_pc(16'hC010, "reach_c010");
      step();
      word_ready = 1'b0;
      redirect(1'b1, 16'h03FE);
      chk(32'(word_valid), 32'(0), "valid_cleared_rel");
      check_next_req(16'hC00E, "rel_back_mab");
      word_ready = 1'b1;
      wait_pc(16'hC00E, "rel_back_pc");

      // absolute redirect while a slow read is in flight
      lat_mode = 3;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (rom_req && !rom_ack) got = 1'b1;
         else step();
      end
      chk(32'(got), 32'(1), "outstanding_found");
      redirect(1'b0, 16'hE001);
      chk(32'(word_valid), 32'(0), "valid_cleared_abs");
      check_next_req(16'hE000, "abs_redir_mab");
      wait_pc(16'hE000, "abs_redir_pc");

      // address wrap and relative wrap
      lat_mode = -1;
      redirect(1'b0, 16'hFFFC);
      wait_pc(16'hFFFC, "wrap_fffc");
      wait_pc(16'hFFFE, "wrap_fffe");
      wait_pc(16'h0000, "wrap_0000");
      redirect(1'b0, 16'hFFF0);
      wait_pc(16'hFFF0, "reach_fff0");
      step();
      word_ready = 1'b0;
      redirect(1'b1, 16'h01FF);
      check_next_req(16'h03F0, "rel_wrap_mab");
      word_ready = 1'b1;
      wait_pc(16'h03F0, "rel_wrap_pc");

      // random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         step();
         word_ready = ($urandom_range(3, 0) != 0);
         if ($urandom_range(19, 0) == 0) begin
            redir_valid = 1'b1;
            redir_rel   = 1'($urandom_range(1, 0));
            redir_val   = 16'($urandom);
         end else begin
            redir_valid = 1'b0;
         end
      end
      redir_valid = 1'b0;
      word_ready  = 1'b1;
      repeat (20) step();
      chk(32'(n_pops > 100), 32'(1), "progress");

      // reset in the middle of a request
      lat_mode = 8;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (rom_req) got = 1'b1;
         else step();
      end
      chk(32'(got), 32'(1), "req_before_reset");
      rst_n = 1'b0;
      #1;
      chk(32'(rom_req),    32'(0),        "midrst_req");
      chk(32'(word_valid), 32'(0),        "midrst_valid");
      chk(32'(vec_done),   32'(0),        "midrst_vec_done");
      chk(32'(MAB),        32'(16'hFFFE), "midrst_mab");
      step();
      step();
      lat_mode = 0;
      rst_n = 1'b1;
      check_next_req(16'hFFFE, "vec_restart");
      wait_pc(16'hC000, "restart_c000");
      chk(32'(vec_done), 32'(1), "restart_vec_done");
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
